// File: rtl/hazard_ctrl.sv
// hazard_ctrl: resolves bus waits, MDU occupancy, load-use and taken branches into
// one stall/flush vector per cycle, and squashes a wrong-path fetch still in flight.
module hazard_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_req,
    input  logic       i_data_ok,
    input  logic       d_req,
    input  logic       d_data_ok,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    input  logic [4:0] rd_E,
    input  logic       memread_E,
    input  logic       mdu_start_E,
    input  logic       mdu_div_E,
    input  logic       branch_taken_E,
    output logic       stall_F,
    output logic       stall_D,
    output logic       stall_E,
    output logic       stall_M,
    output logic       reset_D,
    output logic       reset_E,
    output logic       reset_M,
    output logic       reset_W,
    output logic       mdu_busy,
    output logic       mdu_done
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pend, dwait, iwait, lu, r1, r2, r3, r4, r5, pclr;

    always_comb begin
        dwait    = d_req & ~d_data_ok;
        iwait    = i_req & ~i_data_ok;
        lu       = memread_E & (rd_E != 5'd0) & ((rd_E == rs1_D) | (rd_E == rs2_D));
        mdu_busy = reset & ((state == BUSY) | ((state == IDLE) & mdu_start_E & ~dwait));
        mdu_done = reset & (state == DONE);
        r1       = reset & dwait;
        r2       = reset & ~dwait & mdu_busy;
        r3       = reset & ~dwait & ~mdu_busy & branch_taken_E;
        r4       = reset & ~dwait & ~mdu_busy & ~branch_taken_E & lu;
        r5       = reset & ~dwait & ~mdu_busy & ~branch_taken_E & ~lu & iwait;
        stall_F  = r1 | r2 | r4 | r5;
        stall_D  = r1 | r2 | r4;
        stall_E  = r1 | r2;
        stall_M  = r1;
        reset_W  = r1;
        reset_M  = r2;
        reset_E  = r3 | r4;
        // The returning wrong-path word is squashed as it lands in D.
        pclr     = reset & ~r1 & ~r2 & pend & i_data_ok & ~stall_F;
        reset_D  = r3 | r5 | pclr;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
        end else begin
            pend <= (branch_taken_E & ~stall_E & iwait) ? 1'b1 : pclr ? 1'b0 : pend;
            if (!dwait) begin
                if (state == IDLE && mdu_start_E) begin
                    state <= BUSY;
                    cnt   <= mdu_div_E ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                end else if (state == BUSY) begin
                    cnt   <= cnt - CNT_W'(1);
                    state <= (cnt == CNT_W'(1)) ? DONE : BUSY;
                end else if (state == DONE) begin
                    state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against an
// elapsed-cycle reference model of the hazard priority rules.
module tb_hazard_ctrl;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 32;
    localparam int CNT_W   = 6;

    logic       clk = 1'b0;
    logic       reset, i_req, i_data_ok, d_req, d_data_ok;
    logic [4:0] rs1_D, rs2_D, rd_E;
    logic       memread_E, mdu_start_E, mdu_div_E, branch_taken_E;
    logic       stall_F, stall_D, stall_E, stall_M;
    logic       reset_D, reset_E, reset_M, reset_W, mdu_busy, mdu_done;

    int         checks = 0;
    int         failures = 0;
    int         k = -1;
    int         lat = 0;
    bit         mpend = 1'b0;
    logic [9:0] last_act;
    int         n, busyc;

    hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .i_req(i_req), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_data_ok(d_data_ok), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .rd_E(rd_E), .memread_E(memread_E), .mdu_start_E(mdu_start_E),
        .mdu_div_E(mdu_div_E), .branch_taken_E(branch_taken_E),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .reset_D(reset_D), .reset_E(reset_E), .reset_M(reset_M), .reset_W(reset_W),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int expv);
        checks++;
        assert (act === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, expv);
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cyc(input string tag);
        bit         dw, iw, lu, busy, done;
        int         kc, clat;
        logic [9:0] expv, act;
        #2;
        dw   = d_req && !d_data_ok;
        iw   = i_req && !i_data_ok;
        lu   = memread_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
        clat = (k < 0) ? (mdu_div_E ? DIV_LAT : MUL_LAT) : lat;
        kc   = (k < 0 && mdu_start_E && !dw) ? 0 : k;
        busy = kc >= 0 && kc < clat;
        done = kc == clat;
        expv = '0;
        if (dw)                  expv = 10'b1111000100;
        else if (busy)           expv = 10'b1110001000;
        else if (branch_taken_E) expv = 10'b0000110000;
        else if (lu)             expv = 10'b1100010000;
        else if (iw)             expv = 10'b1000100000;
        if (!dw && !busy && mpend && i_data_ok && !expv[9]) expv[5] = 1'b1;
        expv[1] = busy;
        expv[0] = done;
        if (!reset) expv = '0;
        act = {stall_F, stall_D, stall_E, stall_M, reset_D, reset_E, reset_M, reset_W,
               mdu_busy, mdu_done};
        last_act = act;
        checks++;
        assert (act === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, act, expv);
        end
        @(posedge clk);
        #1;
        if (!reset) begin
            k     = -1;
            mpend = 1'b0;
        end else begin
            if (branch_taken_E && !expv[7] && iw) mpend = 1'b1;
            else if (i_data_ok && !expv[9])       mpend = 1'b0;
            if (!dw && kc >= 0) k = (kc == clat) ? -1 : kc + 1;
            else k = kc;
            lat = clat;
        end
        @(negedge clk);
    endtask

    task automatic idle_in();
        i_req = 0; i_data_ok = 0; d_req = 0; d_data_ok = 0;
        rs1_D = 0; rs2_D = 0; rd_E = 0; memread_E = 0;
        mdu_start_E = 0; mdu_div_E = 0; branch_taken_E = 0;
    endtask

    initial begin
        reset = 0;
        idle_in();
        @(negedge clk);
        mdu_start_E = 1; d_req = 1; branch_taken_E = 1; i_req = 1;
        cyc("reset_a");
        chk("reset_outputs", last_act, 0);
        cyc("reset_b");
        idle_in();
        reset = 1;
        cyc("idle");
        chk("idle_outputs", last_act, 0);

        memread_E = 1; rd_E = 5; rs2_D = 5;
        cyc("lu");
        chk("lu_bubble", last_act, 10'b1100010000);
        memread_E = 0;
        cyc("lu_after");
        chk("lu_one_cycle", last_act, 0);
        memread_E = 1; rd_E = 0; rs1_D = 0; rs2_D = 0;
        cyc("lu_x0");
        chk("lu_rd0", last_act, 0);
        idle_in();

        mdu_start_E = 1;
        for (int c = 0; c < 4; c++) begin
            cyc("mul");
            chk("mul_cycle", last_act, c < MUL_LAT ? 10'b1110001010 : 10'b0000000001);
        end
        mdu_start_E = 0;
        cyc("mul_idle");
        chk("mul_back_idle", last_act, 0);

        mdu_start_E = 1; mdu_div_E = 1; n = -1;
        for (int c = 0; c < 60 && n < 0; c++) begin
            d_req = (c >= 5 && c < 9);
            cyc("div");
            if (c >= 5 && c < 9) chk("div_wait", last_act, 10'b1111000110);
            if (last_act[0]) n = c;
        end
        chk("div_done_cycle", n, DIV_LAT + 4);
        idle_in();
        cyc("div_idle");

        branch_taken_E = 1; i_req = 1;
        cyc("br");
        chk("br_flush", last_act, 10'b0000110000);
        branch_taken_E = 0;
        for (int c = 0; c < 2; c++) begin
            cyc("br_wait");
            chk("br_iwait", last_act, 10'b1000100000);
        end
        i_data_ok = 1;
        cyc("br_ret");
        chk("br_squash", last_act, 10'b0000100000);
        cyc("br_clr");
        chk("br_pend_clear", last_act, 0);
        idle_in();

        branch_taken_E = 1; memread_E = 1; rd_E = 5; rs1_D = 5;
        cyc("br_lu");
        chk("br_over_lu", last_act, 10'b0000110000);
        idle_in();

        mdu_start_E = 1; mdu_div_E = 1;
        for (int c = 0; c < 9; c++) cyc("div2");
        reset = 0;
        cyc("div2_rst");
        chk("rst_mid_div", last_act, 0);
        reset = 1; n = -1; busyc = 0;
        for (int c = 0; c < 60 && n < 0; c++) begin
            cyc("div3");
            if (last_act[7]) busyc++;
            if (last_act[0]) n = c;
        end
        chk("fresh_div_stalls", busyc, DIV_LAT);
        chk("fresh_div_done", n, DIV_LAT);
        idle_in();

        for (int c = 0; c < 3000; c++) begin
            reset          = $urandom_range(0, 59) != 0;
            i_req          = 1'($urandom);
            i_data_ok      = 1'($urandom);
            d_req          = $urandom_range(0, 3) == 0;
            d_data_ok      = 1'($urandom);
            rs1_D          = 5'($urandom_range(0, 3));
            rs2_D          = 5'($urandom_range(0, 3));
            rd_E           = 5'($urandom_range(0, 3));
            memread_E      = 1'($urandom);
            mdu_start_E    = $urandom_range(0, 7) == 0;
            mdu_div_E      = $urandom_range(0, 3) == 0;
            branch_taken_E = $urandom_range(0, 3) == 0;
            cyc("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and control unit that drives the per-stage `stall_*` and `reset_*` (flush) inputs of the F/D/E/M/W pipeline registers. It resolves bus waits, multi-cycle MDU occupancy, load-use hazards and taken branches into one consistent stall/flush vector each cycle. It also tracks a pending redirect so that a wrong-path fetch still in flight is squashed when it returns.

## Interface
- `MUL_LAT`, default 3: multiply stall cycles, ≥2.
- `DIV_LAT`, default 32: divide stall cycles, ≥2.
- `CNT_W`, default 6: MDU counter width; must hold `DIV_LAT-1`.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low.
- `i_req`, `i_data_ok` in 1 each: instruction bus request and response.
- `d_req`, `d_data_ok` in 1 each: data bus request and response, driven from M.
- `rs1_D`, `rs2_D` in 5 each: source registers of the instruction in D.
- `rd_E` in 5: destination register of the instruction in E.
- `memread_E` in 1: the instruction in E is a load.
- `mdu_start_E` in 1: the instruction in E is a mul or div.
- `mdu_div_E` in 1: 1 selects divide latency, 0 selects multiply.
- `branch_taken_E` in 1: the branch in E resolved as taken.
- `stall_F`, `stall_D`, `stall_E`, `stall_M` out 1 each: hold the stage register.
- `reset_D`, `reset_E`, `reset_M`, `reset_W` out 1 each: load a bubble into the stage register.
- `mdu_busy` out 1: the MDU stall is active.
- `mdu_done` out 1: the MDU result is valid this cycle.

## Operation
- Internal wait terms:
  - `dwait = d_req & ~d_data_ok`
  - `iwait = i_req & ~i_data_ok`
- Load-use term `lu`: `memread_E & rd_E!=0 & (rd_E==rs1_D | rd_E==rs2_D)`.
- MDU FSM states are IDLE, BUSY and DONE, with counter `cnt` (CNT_W bits).
  - IDLE, `mdu_start_E=1`, `dwait=0`:
    - `mdu_busy=1` this cycle.
    - Load `cnt = LAT-1`, where LAT is chosen by `mdu_div_E`.
    - Next state is BUSY.
  - BUSY: `mdu_busy=1` and `cnt` decrements by 1. When `cnt==1`, next state is DONE.
  - DONE: `mdu_busy=0` and `mdu_done=1`. Next state is IDLE.
  - DONE exists so that the same E instruction, whose `mdu_start_E` is still high, cannot restart the MDU.
  - While `dwait=1`, the FSM and `cnt` hold in every state.
- Pending-redirect flag `pend`:
  - Set when `branch_taken_E=1`, E is not stalled, and `iwait=1`.
  - Cleared on the first cycle with `i_data_ok=1` and `stall_F=0`. That cycle forces `reset_D=1`, which squashes the wrong-path word.
- Priority resolution: the highest active rule decides all outputs. Outputs not named in the active rule are 0.
  1. `dwait`: `stall_F`, `stall_D`, `stall_E`, `stall_M` and `reset_W` are asserted. No other action is taken and the branch is deferred.
  2. `mdu_busy`: `stall_F`, `stall_D` and `stall_E` are asserted, and `reset_M` is asserted.
  3. `branch_taken_E`: `reset_D` and `reset_E` are asserted, and any `lu` is ignored.
  4. `lu`: `stall_F` and `stall_D` are asserted, and `reset_E` is asserted.
  5. `iwait`: `stall_F` and `reset_D` are asserted.
- The pend-clear `reset_D` is ORed in under rules 3–5.
- All outputs are combinational from the inputs and registered state.

## Timing
- Reset (`reset=0`, sampled at the clock edge):
  - State returns to IDLE, with `cnt=0` and `pend=0`.
  - All outputs are forced to 0 while `reset=0`.
- MDU occupancy:
  - E is stalled for exactly LAT consecutive cycles from the first cycle `mdu_start_E` is seen in IDLE.
  - The (LAT+1)th cycle is DONE with no stall, and the instruction leaves E at the end of it.
  - Each `dwait` cycle during this window adds one cycle.
- Load-use costs exactly one bubble, because `lu` drops once the load moves to M.
- A taken branch costs 2 squashed slots, plus 1 more if `pend` was set.
- `reset=0` mid-MDU operation aborts it immediately. The first cycle after reset is IDLE.
- `dwait` and `branch_taken_E` in the same cycle: only the stall is applied. The flush happens on the first cycle after `dwait` drops.

## Test plan
- Load-use: `memread_E=1`, `rd_E=5`, `rs2_D=5` for one cycle. Required: `stall_F=stall_D=1` and `reset_E=1` for exactly 1 cycle. Repeating with `rd_E=0` gives all outputs 0.
- Multiply: `mdu_start_E=1`, `mdu_div_E=0`, `MUL_LAT=3`. Required: `mdu_busy` and `stall_E` high for cycles 0–2, `reset_M` high for the same 3 cycles, `mdu_done=1` on cycle 3 with `stall_E=0`, then IDLE.
- Divide with dbus wait: start a divide, then hold `d_req=1`, `d_data_ok=0` for 4 cycles mid-divide. Required: `mdu_done` arrives on cycle `DIV_LAT+4`, and `stall_M=reset_W=1` during the 4 wait cycles.
- Branch during ifetch wait: `branch_taken_E=1` with `i_req=1`, `i_data_ok=0`. Required: `reset_D=reset_E=1` that cycle, then `pend=1`. Raising `i_data_ok` 3 cycles later gives `reset_D=1` on that cycle and clears `pend`.
- Branch plus load-use in the same cycle: required `reset_D=reset_E=1` and `stall_F=stall_D=0`.
- Reset mid-divide: drive `reset=0` on the 10th busy cycle. Required: all outputs 0 during reset. After release, `mdu_start_E=1` starts a fresh LAT-cycle stall.
